// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline stall/refresh sequencer.
//   state_t         - sequencer FSM encoding (PC_RUN, PC_DRAIN)
//   DIV_CYCLES_DEF  - default number of cycles the iterative divider holds EX
//   OUTST_W         - width of the outstanding data-transaction counter
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        PC_RUN   = 1'b0,
        PC_DRAIN = 1'b1
    } state_t;

    localparam int DIV_CYCLES_DEF = 33;
    localparam int OUTST_W        = 2;

endpackage

// File: rtl/pipe_div_timer.sv
// pipe_div_timer: occupancy timer for the multi-cycle divider sitting in EX.
// Ports:
//   clk, reset  - core clock, asynchronous active-high reset
//   ex_div      - a valid div/divu is in EX
//   ec_stall    - EC is held; a new division may not start
//   ex_stall    - EX is held; while low the finished result moves on
//   flush       - pipeline flush; discards a finished result
//   div_busy    - counter is running
//   div_done    - division finished, result waiting for EX to advance
module pipe_div_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic ex_div,
    input  logic ec_stall,
    input  logic ex_stall,
    input  logic flush,
    output logic div_busy,
    output logic div_done
);

    localparam int              CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] div_cnt;

    // The start cycle itself counts as the first busy cycle of EX, so the
    // counter is loaded with one less than the total occupancy.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            div_done <= 1'b0;
        end else begin
            if (div_cnt != '0)
                div_cnt <= div_cnt - ONE;
            else if (ex_div && !div_done && !ec_stall)
                div_cnt <= LOAD;

            if (flush)
                div_done <= 1'b0;
            else if (div_cnt == ONE)
                div_done <= 1'b1;
            else if (!ex_stall)
                div_done <= 1'b0;
        end
    end

    assign div_busy = (div_cnt != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/refresh sequencer for the IF/ID/EX/EC/WB core.
// Ports:
//   clk, reset                     - core clock, asynchronous active-high reset
//   inst_wait, inst_busy           - instruction-bus status from IF
//   data_req, data_addr_ok,
//   data_data_ok                   - data-bus handshake seen from EC
//   ec_load_wait                   - EC memory op still waiting for data_ok
//   id_load_use                    - ID needs the result of the load in EX
//   ex_div                         - valid divide in EX
//   ec_exc, ec_eret                - EC instruction redirects the pipeline
//   data_req_ok                    - EC may issue a data request
//   if/id/ex/ec_stall              - hold the corresponding segment register
//   id/ex/ec/wb_refresh            - clear the corresponding segment register
//   div_busy, outst, draining      - status
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int MAX_OUTST  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inst_wait,
    input  logic               inst_busy,
    input  logic               data_req,
    input  logic               data_addr_ok,
    input  logic               data_data_ok,
    input  logic               ec_load_wait,
    input  logic               id_load_use,
    input  logic               ex_div,
    input  logic               ec_exc,
    input  logic               ec_eret,
    output logic               data_req_ok,
    output logic               if_stall,
    output logic               id_stall,
    output logic               ex_stall,
    output logic               ec_stall,
    output logic               id_refresh,
    output logic               ex_refresh,
    output logic               ec_refresh,
    output logic               wb_refresh,
    output logic               div_busy,
    output logic [OUTST_W-1:0] outst,
    output logic               draining
);

    localparam logic [OUTST_W-1:0] MAX_CNT = OUTST_W'(MAX_OUTST);
    localparam logic [OUTST_W-1:0] ONE     = OUTST_W'(1);

    state_t             state;
    logic [OUTST_W-1:0] outst_nxt;
    logic               exc_any;
    logic               room;
    logic               ret;
    logic               inc;
    logic               quiet;
    logic               flush;
    logic               hold;
    logic               div_done;
    logic               b_ec_stall;
    logic               b_ex_stall;
    logic               b_id_stall;
    logic               b_if_stall;

    assign exc_any = ec_exc | ec_eret;
    assign room    = (outst < MAX_CNT);

    // A response with nothing outstanding is dropped so the counter cannot
    // wrap; an acceptance at the limit only counts if a response frees a slot.
    assign ret = data_data_ok & (outst != '0);
    assign inc = data_req & data_addr_ok & (room | ret);

    always_comb begin
        outst_nxt = outst;
        if (inc && !ret)
            outst_nxt = outst + ONE;
        else if (ret && !inc)
            outst_nxt = outst - ONE;
    end

    // "Quiet" looks at the post-edge count so a data_data_ok arriving this
    // cycle allows the flush in the same cycle.
    assign quiet = (outst_nxt == '0) & !inst_busy;
    assign flush = !reset & quiet & ((state == PC_RUN & exc_any) | (state == PC_DRAIN));
    assign hold  = !reset & !flush & ((state == PC_RUN & exc_any) | (state == PC_DRAIN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PC_RUN;
            outst <= '0;
        end else begin
            outst <= outst_nxt;
            case (state)
                PC_RUN:   if (exc_any && !quiet) state <= PC_DRAIN;
                PC_DRAIN: if (quiet)             state <= PC_RUN;
                default:                         state <= PC_RUN;
            endcase
        end
    end

    // Base hazard chain: a hold in a later stage holds every earlier stage.
    assign b_ec_stall = (data_req & !data_addr_ok) | ec_load_wait;
    assign b_ex_stall = b_ec_stall | (ex_div & !div_done);
    assign b_id_stall = b_ex_stall | id_load_use;
    assign b_if_stall = b_id_stall | inst_wait;

    // NOTE: every output gets a default at the top of the block so no path
    // through the if/else chain leaves one unassigned and infers a latch.
    always_comb begin
        if_stall   = b_if_stall;
        id_stall   = b_id_stall;
        ex_stall   = b_ex_stall;
        ec_stall   = b_ec_stall;
        // A bubble goes into a segment whose predecessor holds while it moves.
        id_refresh = b_if_stall & !b_id_stall;
        ex_refresh = b_id_stall & !b_ex_stall;
        ec_refresh = b_ex_stall & !b_ec_stall;
        wb_refresh = b_ec_stall;
        if (reset || flush) begin
            if_stall   = 1'b0;
            id_stall   = 1'b0;
            ex_stall   = 1'b0;
            ec_stall   = 1'b0;
            id_refresh = 1'b1;
            ex_refresh = 1'b1;
            ec_refresh = 1'b1;
            wb_refresh = 1'b1;
        end else if (hold) begin
            if_stall   = 1'b1;
            id_stall   = 1'b1;
            ex_stall   = 1'b1;
            ec_stall   = 1'b1;
            id_refresh = 1'b0;
            ex_refresh = 1'b0;
            ec_refresh = 1'b0;
            wb_refresh = 1'b0;
        end
    end

    assign data_req_ok = (state == PC_RUN) & !exc_any & room;
    assign draining    = (state == PC_DRAIN);

    pipe_div_timer #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .ex_div   (ex_div),
        .ec_stall (ec_stall),
        .ex_stall (ex_stall),
        .flush    (flush),
        .div_busy (div_busy),
        .div_done (div_done)
    );

    // A response with no transaction outstanding indicates a bus protocol bug.
    assert property (@(posedge clk) disable iff (reset) !(data_data_ok && outst == '0));

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       inst_wait, inst_busy, data_req, data_addr_ok, data_data_ok;
    logic       ec_load_wait, id_load_use, ex_div, ec_exc, ec_eret;
    logic       data_req_ok, if_stall, id_stall, ex_stall, ec_stall;
    logic       id_refresh, ex_refresh, ec_refresh, wb_refresh;
    logic       div_busy, draining;
    logic [1:0] outst;

    logic [3:0] stalls;
    logic [3:0] refr;
    int         n_vec = 0;
    int         n_err = 0;

    assign stalls = {if_stall, id_stall, ex_stall, ec_stall};
    assign refr   = {id_refresh, ex_refresh, ec_refresh, wb_refresh};

    always #5 clk = ~clk;

    pipe_ctrl #(
        .DIV_CYCLES(33),
        .MAX_OUTST (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_wait    (inst_wait),
        .inst_busy    (inst_busy),
        .data_req     (data_req),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .ec_load_wait (ec_load_wait),
        .id_load_use  (id_load_use),
        .ex_div       (ex_div),
        .ec_exc       (ec_exc),
        .ec_eret      (ec_eret),
        .data_req_ok  (data_req_ok),
        .if_stall     (if_stall),
        .id_stall     (id_stall),
        .ex_stall     (ex_stall),
        .ec_stall     (ec_stall),
        .id_refresh   (id_refresh),
        .ex_refresh   (ex_refresh),
        .ec_refresh   (ec_refresh),
        .wb_refresh   (wb_refresh),
        .div_busy     (div_busy),
        .outst        (outst),
        .draining     (draining)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then changed
    // and sampled a further #1 later, well away from either clock edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        inst_wait    = 1'b0;
        inst_busy    = 1'b0;
        data_req     = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        ec_load_wait = 1'b0;
        id_load_use  = 1'b0;
        ex_div       = 1'b0;
        ec_exc       = 1'b0;
        ec_eret      = 1'b0;

        // Reset state
        #2;
        check("rst_stalls",   stalls,   4'b0000);
        check("rst_refresh",  refr,     4'b1111);
        check("rst_outst",    outst,    2'd0);
        check("rst_draining", draining, 1'b0);
        check("rst_div_busy", div_busy, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("idle_stalls",  stalls,      4'b0000);
        check("idle_refresh", refr,        4'b0000);
        check("idle_req_ok",  data_req_ok, 1'b1);

        // Load-use: ID and IF hold, bubble into EX
        tick();
        id_load_use = 1'b1;
        #1;
        check("lu_stalls",  stalls, 4'b1100);
        check("lu_refresh", refr,   4'b0100);
        tick();
        id_load_use = 1'b0;
        #1;
        check("lu_after_stalls",  stalls, 4'b0000);
        check("lu_after_refresh", refr,   4'b0000);

        // inst_wait alone: IF holds, bubble into ID
        inst_wait = 1'b1;
        #1;
        check("iw_stalls",  stalls, 4'b1000);
        check("iw_refresh", refr,   4'b1000);
        tick();
        inst_wait = 1'b0;

        // Divider: EX held 33 cycles, busy for the last 32 of them
        ex_div = 1'b1;
        for (int i = 0; i < 33; i++) begin
            #1;
            check("div_ex_stall",   ex_stall,   1'b1);
            check("div_ec_refresh", ec_refresh, 1'b1);
            check("div_busy",       div_busy,   (i != 0) ? 1'b1 : 1'b0);
            tick();
        end
        #1;
        check("div_adv_ex_stall", ex_stall, 1'b0);
        check("div_adv_busy",     div_busy, 1'b0);
        check("div_adv_refresh",  refr,     4'b0000);
        tick();
        // div_done has cleared, so a new divide in EX stalls again
        #1;
        check("div2_ex_stall", ex_stall, 1'b1);
        check("div2_busy",     div_busy, 1'b0);
        tick();
        ex_div = 1'b0;
        repeat (34) tick();
        #1;
        check("div2_idle_busy",   div_busy, 1'b0);
        check("div2_idle_stalls", stalls,   4'b0000);

        // Data request not accepted: EC and everything above hold, WB bubble
        tick();
        data_req = 1'b1;
        #1;
        check("na_stalls",  stalls, 4'b1111);
        check("na_refresh", refr,   4'b0001);

        // Outstanding accounting
        data_addr_ok = 1'b1;
        #1;
        check("acc_req_ok", data_req_ok, 1'b1);
        check("acc_stalls", stalls,      4'b0000);
        tick();
        #1;
        check("outst_1", outst, 2'd1);
        tick();
        data_req     = 1'b0;
        data_addr_ok = 1'b0;
        #1;
        check("outst_2",      outst,       2'd2);
        check("full_req_ok",  data_req_ok, 1'b0);
        data_req     = 1'b1;
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        tick();
        data_req     = 1'b0;
        data_addr_ok = 1'b0;
        #1;
        check("outst_same", outst, 2'd2);
        tick();
        #1;
        check("outst_dec1", outst, 2'd1);
        tick();
        data_data_ok = 1'b0;
        #1;
        check("outst_dec0",   outst,       2'd0);
        check("empty_req_ok", data_req_ok, 1'b1);

        // Exception with buses quiet: same-cycle flush
        tick();
        ec_exc = 1'b1;
        #1;
        check("exq_stalls",   stalls,      4'b0000);
        check("exq_refresh",  refr,        4'b1111);
        check("exq_req_ok",   data_req_ok, 1'b0);
        check("exq_draining", draining,    1'b0);
        tick();
        ec_exc = 1'b0;
        #1;
        check("exq_after_draining", draining, 1'b0);
        check("exq_after_refresh",  refr,     4'b0000);

        // eret while instruction bus busy: drain until inst_busy drops
        tick();
        ec_eret   = 1'b1;
        inst_busy = 1'b1;
        #1;
        check("ib_stalls", stalls, 4'b1111);
        tick();
        #1;
        check("ib_draining", draining, 1'b1);
        inst_busy = 1'b0;
        #1;
        check("ib_flush_refresh", refr,   4'b1111);
        check("ib_flush_stalls",  stalls, 4'b0000);
        tick();
        ec_eret = 1'b0;
        #1;
        check("ib_run", draining, 1'b0);

        // Exception with one transaction outstanding
        tick();
        data_req     = 1'b1;
        data_addr_ok = 1'b1;
        tick();
        data_req     = 1'b0;
        data_addr_ok = 1'b0;
        ec_exc       = 1'b1;
        #1;
        check("exd_outst",   outst,       2'd1);
        check("exd_stalls",  stalls,      4'b1111);
        check("exd_refresh", refr,        4'b0000);
        check("exd_req_ok",  data_req_ok, 1'b0);
        for (int i = 1; i < 4; i++) begin
            tick();
            #1;
            check("drain_draining", draining,    1'b1);
            check("drain_stalls",   stalls,      4'b1111);
            check("drain_req_ok",   data_req_ok, 1'b0);
        end
        tick();
        data_data_ok = 1'b1;
        #1;
        check("drain_flush_refresh", refr,     4'b1111);
        check("drain_flush_stalls",  stalls,   4'b0000);
        check("drain_flush_state",   draining, 1'b1);
        tick();
        data_data_ok = 1'b0;
        ec_exc       = 1'b0;
        #1;
        check("drain_done_state", draining, 1'b0);
        check("drain_done_outst", outst,    2'd0);
        check("drain_done_stall", stalls,   4'b0000);

        // Reset in the middle of a drain with two outstanding
        tick();
        data_req     = 1'b1;
        data_addr_ok = 1'b1;
        tick();
        tick();
        data_req     = 1'b0;
        data_addr_ok = 1'b0;
        ec_exc       = 1'b1;
        tick();
        #1;
        check("rd_draining", draining, 1'b1);
        check("rd_outst",    outst,    2'd2);
        reset = 1'b1;
        #1;
        check("rd_rst_outst",    outst,    2'd0);
        check("rd_rst_draining", draining, 1'b0);
        check("rd_rst_refresh",  refr,     4'b1111);
        check("rd_rst_stalls",   stalls,   4'b0000);
        ec_exc = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("rd_post_state",   draining, 1'b0);
        check("rd_post_refresh", refr,     4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/refresh sequencer for the five-stage core (IF, ID, EX, EC, WB).
- Drives the stall and refresh inputs of every pipeline segment register (if_id, id_ex, ex_ec, ec_wb).
- Tracks outstanding data-bus transactions and the multi-cycle divider.
- Ensures exception/eret flushes happen only once the buses are quiet.

Parameters:
DIV_CYCLES, 33, cycles the iterative divider occupies EX (>=2)
MAX_OUTST, 2, maximum data requests accepted but not yet answered (1..3)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
inst_wait  in  1  IF is waiting for an instruction data_ok
inst_busy  in  1  an instruction-bus transaction is in flight
data_req  in  1  EC presents a data request
data_addr_ok  in  1  data bus accepted the request
data_data_ok  in  1  data bus returned data/ack
ec_load_wait  in  1  EC holds a load/store whose data_ok has not yet arrived
id_load_use  in  1  ID operand depends on the load in EX
ex_div  in  1  valid div/divu in EX
ec_exc  in  1  EC instruction carries an exception (ec_ex != 0)
ec_eret  in  1  EC instruction is eret
data_req_ok  out  1  EC may assert data_req this cycle
if_stall, id_stall, ex_stall, ec_stall  out  1 each  segment hold
id_refresh, ex_refresh, ec_refresh, wb_refresh  out  1 each  segment clear (bubble/flush)
div_busy  out  1  divider running
outst  out  2  outstanding data transactions
draining  out  1  FSM in DRAIN

Behaviour:
- Reset: state=RUN, outst=0, div_cnt=0, div_done=0. While reset is high, all stalls=0 and all refreshes=1. A mid-drain reset abandons the drain.
- outst: +1 on data_req&data_addr_ok; -1 on data_data_ok; both in the same cycle leaves it unchanged. It never exceeds MAX_OUTST and never underflows. A data_data_ok with outst=0 is ignored and flagged by a simulation assertion.
- data_req_ok = state==RUN & !ec_exc & !ec_eret & outst<MAX_OUTST.
- Divider:
  - ex_div & div_cnt==0 & !div_done & !ec_stall loads div_cnt=DIV_CYCLES-1.
  - div_cnt decrements every cycle while nonzero.
  - The 1->0 transition sets div_done.
  - div_done clears when EX advances (!ex_stall) or on any flush.
  - div_busy = div_cnt!=0.
- Base stall chain (RUN, no flush):
  - ec_stall = (data_req & !data_addr_ok) | ec_load_wait
  - ex_stall = ec_stall | (ex_div & !div_done)
  - id_stall = ex_stall | id_load_use
  - if_stall = id_stall | inst_wait
- Bubbles (RUN, no flush):
  - ex_refresh = id_stall & !ex_stall
  - ec_refresh = ex_stall & !ec_stall
  - wb_refresh = ec_stall
  - id_refresh = if_stall & !id_stall
- FSM states RUN, DRAIN.
  - RUN, ec_exc|ec_eret, next outst==0 and !inst_busy: flush this cycle. id/ex/ec/wb_refresh=1, all stalls=0, state stays RUN.
  - RUN, ec_exc|ec_eret, otherwise: go to DRAIN. All stalls=1, refreshes=0, no new data requests.
  - DRAIN: hold everything until outst==0 and !inst_busy (data_data_ok counted in the same cycle). Then assert the full flush for one cycle and return to RUN.
  - ec_exc and ec_eret together are treated as one flush.
- A flush overrides every stall and bubble term.
- Outputs are combinational from the state/counter registers and inputs. The only state is the FSM, outst, div_cnt and div_done.

Decomposition:
- Shared header (head.vh) gets:
  - state encodings PC_RUN/PC_DRAIN
  - `DIV_CYCLES default
  - the outstanding-count width
- One sub-module, pipe_div_timer (div_cnt/div_done), is natural. Everything else stays flat.

Test Plan:
1. Load-use: id_load_use=1 for one cycle, no other hazards -> id_stall=if_stall=1, ex_refresh=1, ec_stall=0. Next cycle all 0.
2. Divider, DIV_CYCLES=33: ex_div held high -> ex_stall=1 for exactly 33 cycles with ec_refresh=1 each cycle. div_busy falls after 32 cycles. EX advances on cycle 34 and div_done clears.
3. Outstanding accounting:
   - two accepted requests -> outst=2 and data_req_ok=0 (MAX_OUTST=2)
   - simultaneous addr_ok and data_ok -> outst stays 2
   - two data_ok -> outst=0
4. Exception with bus quiet: ec_exc=1, outst=0, inst_busy=0 -> same-cycle id/ex/ec/wb_refresh=1, all stalls 0, state RUN.
5. Exception while outst=1: ec_exc=1 -> draining=1, all stalls 1 and data_req_ok=0. data_data_ok arrives 4 cycles later -> that cycle full flush, next cycle RUN.
6. Reset asserted in DRAIN with outst=2 -> immediately outst=0, state RUN, refreshes=1, stalls=0.
